// File: rtl/mp3_types.sv
// Shared types for the memory-path blocks.
//   arb_state_t : arbiter FSM states
//   arb_side_t  : which L1 requester (I or D) owns the memory port
//   DEF_ADDR_W / DEF_LINE_W : default byte-address and cache-line widths
package mp3_types;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_LINE_W = 128;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        DONE    = 2'd3
    } arb_state_t;

    typedef enum logic {
        SIDE_I = 1'b0,
        SIDE_D = 1'b1
    } arb_side_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of every signal between the L1 caches, the arbiter and physical memory.
//   i_*    : I-cache miss path (read only)
//   d_*    : D-cache miss / writeback path
//   pmem_* : single physical-memory port
// Modports:
//   slave  : the arbiter's view (takes cache requests, drives the pmem command)
//   master : the environment's view (caches plus memory)
interface mem_arbiter_if #(
    parameter int ADDR_W = mp3_types::DEF_ADDR_W,
    parameter int LINE_W = mp3_types::DEF_LINE_W
);
    logic              i_read;
    logic [ADDR_W-1:0] i_address;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;

    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_address;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;

    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;

    modport slave (
        input  i_read, i_address, d_read, d_write, d_address, d_wdata,
        input  pmem_rdata, pmem_resp,
        output i_rdata, i_resp, d_rdata, d_resp,
        output pmem_read, pmem_write, pmem_address, pmem_wdata
    );

    modport master (
        output i_read, i_address, d_read, d_write, d_address, d_wdata,
        output pmem_rdata, pmem_resp,
        input  i_rdata, i_resp, d_rdata, d_resp,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata
    );

endinterface

// File: rtl/mem_arbiter.sv
// Two-into-one arbiter: serialises I-cache and D-cache line requests onto
// the single physical-memory port.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : mem_arbiter_if.slave (cache request/response + pmem port)
// Contended requests alternate, starting with D out of reset. Each
// transaction is IDLE -> SERVE_x -> DONE -> IDLE, so the pmem command
// always drops for at least one cycle between transactions.
module mem_arbiter
    import mp3_types::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LINE_W = DEF_LINE_W
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);

    arb_state_t        state, next_state;
    arb_side_t         last_grant, grant;
    logic              i_pend, d_pend, take;

    logic [ADDR_W-1:0] req_addr;
    logic [LINE_W-1:0] req_wdata;
    logic              req_write;

    assign i_pend = bus.i_read;
    assign d_pend = bus.d_read | bus.d_write;
    assign take   = (state == IDLE) && (i_pend || d_pend);

    // State register.
    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge values; blocking assignments here would create ordering races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= SIDE_I;
        end else begin
            state <= next_state;
            if (take) last_grant <= grant;
        end
    end

    // Next-state logic and grant selection.
    always_comb begin
        // NOTE: defaults first so every path assigns every output; a missing
        // branch would otherwise infer a latch.
        next_state = state;
        grant      = last_grant;
        case (state)
            IDLE: begin
                if (i_pend && d_pend)
                    grant = (last_grant == SIDE_I) ? SIDE_D : SIDE_I;
                else if (d_pend)
                    grant = SIDE_D;
                else
                    grant = SIDE_I;
                if (take)
                    next_state = (grant == SIDE_D) ? SERVE_D : SERVE_I;
            end
            SERVE_I, SERVE_D: begin
                if (bus.pmem_resp) next_state = DONE;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Request latch: captured once on the grant so the requester may change
    // or drop its inputs while the memory works.
    // NOTE: these are reset so pmem_address/pmem_wdata read 0 out of reset;
    // large storage arrays would normally be left unreset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_addr  <= '0;
            req_wdata <= '0;
            req_write <= 1'b0;
        end else if (take) begin
            req_addr  <= (grant == SIDE_D) ? bus.d_address : bus.i_address;
            req_wdata <= (grant == SIDE_D) ? bus.d_wdata   : '0;
            req_write <= (grant == SIDE_D) && bus.d_write;
        end
    end

    // Outputs. Everything decodes from the state, so an asynchronous reset
    // drops the pmem command and any resp immediately.
    always_comb begin
        bus.pmem_read    = ((state == SERVE_I) || (state == SERVE_D)) && !req_write;
        bus.pmem_write   = ((state == SERVE_I) || (state == SERVE_D)) &&  req_write;
        bus.pmem_address = req_addr;
        bus.pmem_wdata   = req_wdata;
        bus.i_resp       = (state == SERVE_I) && bus.pmem_resp;
        bus.d_resp       = (state == SERVE_D) && bus.pmem_resp;
        // Both sides see the memory data; only the one with resp high samples.
        bus.i_rdata      = bus.pmem_rdata;
        bus.d_rdata      = bus.pmem_rdata;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: single I read, D writeback
// with input changes mid-flight, contended start from reset, alternating
// grants, reset mid-transaction and spurious pmem_resp.
module tb_mem_arbiter;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    mem_arbiter_if #(.ADDR_W(16), .LINE_W(128)) bus ();

    mem_arbiter #(.ADDR_W(16), .LINE_W(128)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check("rst pmem_read",  128'(bus.pmem_read),  128'd0);
        check("rst pmem_write", 128'(bus.pmem_write), 128'd0);
        check("rst pmem_addr",  128'(bus.pmem_address), 128'd0);
        check("rst i_resp",     128'(bus.i_resp),     128'd0);
        check("rst d_resp",     128'(bus.d_resp),     128'd0);
    endtask

    // Called in the first cycle after the grant edge. Holds the memory busy
    // for lat cycles (responding in the last), then steps into DONE.
    task automatic serve(input string tag, input bit exp_d, input bit exp_wr,
                         input logic [15:0] exp_addr, input logic [127:0] exp_wdata,
                         input logic [127:0] rdata, input int lat);
        for (int c = 0; c < lat; c++) begin
            check($sformatf("%s rd c%0d", tag, c),   128'(bus.pmem_read),  128'(!exp_wr));
            check($sformatf("%s wr c%0d", tag, c),   128'(bus.pmem_write), 128'(exp_wr));
            check($sformatf("%s addr c%0d", tag, c), 128'(bus.pmem_address), 128'(exp_addr));
            if (exp_wr)
                check($sformatf("%s wdata c%0d", tag, c), bus.pmem_wdata, exp_wdata);
            check($sformatf("%s early resp c%0d", tag, c), 128'({bus.i_resp, bus.d_resp}), 128'd0);
            if (c < lat - 1) tick();
        end
        bus.pmem_rdata = rdata;
        bus.pmem_resp  = 1'b1;
        #1;
        check({tag, " i_resp"}, 128'(bus.i_resp), 128'(!exp_d));
        check({tag, " d_resp"}, 128'(bus.d_resp), 128'(exp_d));
        if (exp_d) check({tag, " d_rdata"}, bus.d_rdata, rdata);
        else       check({tag, " i_rdata"}, bus.i_rdata, rdata);
        tick();
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = '0;
        #1;
        check({tag, " done rd"},   128'(bus.pmem_read),  128'd0);
        check({tag, " done wr"},   128'(bus.pmem_write), 128'd0);
        check({tag, " done resp"}, 128'({bus.i_resp, bus.d_resp}), 128'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.i_read = 1'b0;  bus.i_address = '0;
        bus.d_read = 1'b0;  bus.d_write = 1'b0;
        bus.d_address = '0; bus.d_wdata = '0;
        bus.pmem_rdata = '0; bus.pmem_resp = 1'b0;

        apply_reset();

        // I-only read of 0x1230, memory answers in the 4th cycle.
        bus.i_read = 1'b1;
        bus.i_address = 16'h1230;
        tick();
        serve("i_only", 1'b0, 1'b0, 16'h1230, '0, {16{8'hA5}}, 4);
        bus.i_read = 1'b0;

        // D writeback; inputs change and the request drops mid-flight.
        bus.d_write = 1'b1;
        bus.d_address = 16'h0040;
        bus.d_wdata = {4{32'hDEADBEEF}};
        tick();
        tick();
        bus.d_write = 1'b0;
        bus.d_address = 16'hFFFF;
        bus.d_wdata = '0;
        serve("d_wb", 1'b1, 1'b1, 16'h0040, {4{32'hDEADBEEF}}, '0, 3);

        // Both rise together after reset: D first, then I.
        apply_reset();
        bus.i_address = 16'h2000;
        bus.d_address = 16'h3000;
        bus.i_read = 1'b1;
        bus.d_read = 1'b1;
        tick();
        serve("both_d", 1'b1, 1'b0, 16'h3000, '0, {4{32'h0D0D0D0D}}, 2);
        bus.d_read = 1'b0;
        tick();
        tick();
        serve("both_i", 1'b0, 1'b0, 16'h2000, '0, {4{32'h11111111}}, 2);

        // Continuous contention: D,I,D,I,D,I.
        bus.d_read = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            tick();
            if (k % 2 == 0)
                serve($sformatf("alt%0d_d", k), 1'b1, 1'b0, 16'h3000, '0, 128'(k + 100), 2);
            else
                serve($sformatf("alt%0d_i", k), 1'b0, 1'b0, 16'h2000, '0, 128'(k + 200), 2);
        end

        // Reset two cycles into a D read.
        bus.i_read = 1'b0;
        tick();
        tick();
        check("rstmid rd c1", 128'(bus.pmem_read), 128'd1);
        tick();
        check("rstmid rd c2", 128'(bus.pmem_read), 128'd1);
        rst_n = 1'b0;
        #1;
        check("rstmid rd drop", 128'(bus.pmem_read), 128'd0);
        bus.pmem_resp = 1'b1;
        #1;
        check("rstmid no d_resp", 128'(bus.d_resp), 128'd0);
        tick();
        bus.pmem_resp = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        check("rstmid idle rd", 128'(bus.pmem_read), 128'd0);
        tick();
        serve("rstmid regrant", 1'b1, 1'b0, 16'h3000, '0, {4{32'h33333333}}, 2);

        // Spurious pmem_resp in DONE and IDLE.
        bus.d_read = 1'b0;
        bus.pmem_resp = 1'b1;
        #1;
        check("spur done resp", 128'({bus.i_resp, bus.d_resp}), 128'd0);
        tick();
        check("spur idle resp", 128'({bus.i_resp, bus.d_resp}), 128'd0);
        check("spur idle cmd",  128'({bus.pmem_read, bus.pmem_write}), 128'd0);
        bus.pmem_resp = 1'b0;
        bus.i_read = 1'b1;
        bus.i_address = 16'h0ABC;
        tick();
        serve("spur after", 1'b0, 1'b0, 16'h0ABC, '0, {4{32'h55AA55AA}}, 2);
        bus.i_read = 1'b0;
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
